mips_regfile_mp: RTL and testbench

//   Multi-port MIPS register file: NUM_RD async read ports and NUM_WR write ports.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_scoreboard.sv | 61 ++++++
 rtl/mips_regfile_mp.sv | 85 ++++++++
 tb/tb_mips_regfile_mp.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths, depth and address helpers for the multi-port MIPS register file.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned ADDR_W_DEF   = 5;
    localparam int unsigned NUM_REGS_DEF = 32;
    localparam int unsigned NUM_RD_DEF   = 2;
    localparam int unsigned NUM_WR_DEF   = 2;

    // Register 0 is hardwired to zero and can never be written or reserved.
    localparam int unsigned REG_ZERO = 0;

    // True when addr names a real, writable register (non-zero and below the depth).
    function automatic logic is_valid_addr(input logic [31:0] addr, input int unsigned num_regs);
        return (addr != 32'(REG_ZERO)) && (addr < num_regs);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: multi-cycle producers reserve a destination, committed writes release it.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned NUM_WR   = NUM_WR_DEF
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    output logic [NUM_REGS-1:0]      busy,
    output logic                     rsv_err,
    output logic [ADDR_W:0]          pend_cnt
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                rsv_err_q, rsv_err_d;
    logic [ADDR_W:0]     pend_cnt_q, pend_cnt_d;

    // Writes clear first, then a reserve sets, so a same-cycle reserve outlives the write it races.
    always_comb begin
        busy_d    = busy_q;
        rsv_err_d = 1'b0;
        for (int k = 0; k < int'(NUM_WR); k++) begin
            if (wr_en[k] && is_valid_addr(32'(wr_addr[k*ADDR_W +: ADDR_W]), NUM_REGS)) begin
                busy_d[wr_addr[k*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (rsv_en) begin
            if (!is_valid_addr(32'(rsv_addr), NUM_REGS)) begin
                rsv_err_d = 1'b1;
            end else begin
                rsv_err_d = busy_q[rsv_addr];
                busy_d[rsv_addr] = 1'b1;
            end
        end
        pend_cnt_d = (ADDR_W+1)'($countones(busy_d));
    end

    // Busy vector, error pulse and pending count all update together; reset drops everything.
    always_ff @(posedge CLK) begin
        if (rst) begin
            busy_q     <= '0;
            rsv_err_q  <= 1'b0;
            pend_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            rsv_err_q  <= rsv_err_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign busy     = busy_q;
    assign rsv_err  = rsv_err_q;
    assign pend_cnt = pend_cnt_q;

endmodule

// File: rtl/mips_regfile_mp.sv
// Multi-port MIPS register file with async reads, prioritised writes and a busy-bit scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module mips_regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned NUM_RD   = NUM_RD_DEF,
    parameter int unsigned NUM_WR   = NUM_WR_DEF
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     rsv_err,
    output logic [ADDR_W:0]          pend_cnt
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .NUM_WR   (NUM_WR)
    ) u_scoreboard (
        .CLK      (CLK),
        .rst      (rst),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .busy     (busy),
        .rsv_err  (rsv_err),
        .pend_cnt (pend_cnt)
    );

    // Ports are applied in ascending order so the highest-index port wins an address collision.
    always_comb begin
        regs_d = regs_q;
        for (int k = 0; k < int'(NUM_WR); k++) begin
            if (wr_en[k] && is_valid_addr(32'(wr_addr[k*ADDR_W +: ADDR_W]), NUM_REGS)) begin
                regs_d[wr_addr[k*ADDR_W +: ADDR_W]] = wr_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Register array; reset wins over any same-cycle write.
    always_ff @(posedge CLK) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read muxes: reg 0 and out-of-range addresses read zero and never look busy.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < int'(NUM_RD); i++) begin
            if (is_valid_addr(32'(rd_addr[i*ADDR_W +: ADDR_W]), NUM_REGS)) begin
                rd_data[i*DATA_W +: DATA_W] = regs_q[rd_addr[i*ADDR_W +: ADDR_W]];
                rd_busy[i]                  = busy[rd_addr[i*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
                for (int k = 0; k < int'(NUM_WR); k++) begin
                    if (wr_en[k] && (wr_addr[k*ADDR_W +: ADDR_W] == rd_addr[i*ADDR_W +: ADDR_W])) begin
                        rd_data[i*DATA_W +: DATA_W] = wr_data[k*DATA_W +: DATA_W];
                        rd_busy[i]                  = 1'b0;
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Directed self-checking bench for mips_regfile_mp (default parameters, 2 read / 2 write ports).
module tb_mips_regfile_mp;

    logic        CLK;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        rsv_err;
    logic [5:0]  pend_cnt;

    int vectors;
    int miscompares;

    mips_regfile_mp dut (
        .CLK      (CLK),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rsv_err  (rsv_err),
        .pend_cnt (pend_cnt)
    );

    // 10 ns clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic idle();
        wr_en    = 2'b00;
        wr_addr  = '0;
        wr_data  = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
    endtask

    // Advance past the next rising edge so outputs have settled.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        rd_addr = '0;
        tick();
        tick();
        rst = 1'b0;
        for (int a = 0; a < 32; a += 2) begin
            rd_addr = {5'(a + 1), 5'(a)};
            #1;
            vectors++;
            if (rd_data !== 64'h0) begin
                miscompares++;
                $display("[TB] FAIL reset_rd_data addr=%0d got=%h exp=0", a, rd_data);
            end
            vectors++;
            if (rd_busy !== 2'b00) begin
                miscompares++;
                $display("[TB] FAIL reset_rd_busy addr=%0d got=%b exp=00", a, rd_busy);
            end
        end
        vectors++;
        if (pend_cnt !== 6'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_pend_cnt got=%0d exp=0", pend_cnt);
        end
        vectors++;
        if (rsv_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_rsv_err got=%b exp=0", rsv_err);
        end
    endtask

    task automatic test_write_priority();
        wr_en   = 2'b11;
        wr_addr = {5'd5, 5'd5};
        wr_data = {32'h1234_5678, 32'hDEAD_BEEF};
        tick();
        idle();
        rd_addr = {5'd5, 5'd5};
        #1;
        vectors++;
        if (rd_data[31:0] !== 32'h1234_5678) begin
            miscompares++;
            $display("[TB] FAIL prio_port0 got=%h exp=12345678", rd_data[31:0]);
        end
        vectors++;
        if (rd_data[63:32] !== 32'h1234_5678) begin
            miscompares++;
            $display("[TB] FAIL prio_port1 got=%h exp=12345678", rd_data[63:32]);
        end
    endtask

    task automatic test_addr_zero();
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd0};
        wr_data = {32'h0, 32'hFFFF_FFFF};
        tick();
        idle();
        rd_addr = {5'd5, 5'd0};
        #1;
        vectors++;
        if (rd_data[31:0] !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL zero_read got=%h exp=0", rd_data[31:0]);
        end
        rsv_en   = 1'b1;
        rsv_addr = 5'd0;
        tick();
        idle();
        vectors++;
        if (rsv_err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL zero_rsv_err got=%b exp=1", rsv_err);
        end
        vectors++;
        if (pend_cnt !== 6'd0) begin
            miscompares++;
            $display("[TB] FAIL zero_pend_cnt got=%0d exp=0", pend_cnt);
        end
        tick();
        vectors++;
        if (rsv_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL zero_rsv_err_pulse got=%b exp=0", rsv_err);
        end
    endtask

    task automatic test_reserve();
        rsv_en   = 1'b1;
        rsv_addr = 5'd7;
        tick();
        idle();
        rd_addr = {5'd7, 5'd0};
        #1;
        vectors++;
        if (rd_busy !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL rsv_busy got=%b exp=10", rd_busy);
        end
        vectors++;
        if (pend_cnt !== 6'd1) begin
            miscompares++;
            $display("[TB] FAIL rsv_pend_cnt got=%0d exp=1", pend_cnt);
        end
        vectors++;
        if (rsv_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rsv_first_err got=%b exp=0", rsv_err);
        end
        rsv_en   = 1'b1;
        rsv_addr = 5'd7;
        tick();
        idle();
        vectors++;
        if (rsv_err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rsv_again_err got=%b exp=1", rsv_err);
        end
        vectors++;
        if (pend_cnt !== 6'd1) begin
            miscompares++;
            $display("[TB] FAIL rsv_again_pend got=%0d exp=1", pend_cnt);
        end
        wr_en   = 2'b10;
        wr_addr = {5'd7, 5'd0};
        wr_data = {32'h0000_00A5, 32'h0};
        tick();
        idle();
        vectors++;
        if (rsv_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rsv_err_clear got=%b exp=0", rsv_err);
        end
        vectors++;
        if (rd_busy !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL rsv_write_busy got=%b exp=00", rd_busy);
        end
        vectors++;
        if (pend_cnt !== 6'd0) begin
            miscompares++;
            $display("[TB] FAIL rsv_write_pend got=%0d exp=0", pend_cnt);
        end
        vectors++;
        if (rd_data[63:32] !== 32'h0000_00A5) begin
            miscompares++;
            $display("[TB] FAIL rsv_write_data got=%h exp=000000a5", rd_data[63:32]);
        end
    endtask

    task automatic test_rsv_write_same();
        rsv_en   = 1'b1;
        rsv_addr = 5'd9;
        wr_en    = 2'b01;
        wr_addr  = {5'd0, 5'd9};
        wr_data  = {32'h0, 32'h0000_0042};
        tick();
        idle();
        rd_addr = {5'd0, 5'd9};
        #1;
        vectors++;
        if (rd_data[31:0] !== 32'h0000_0042) begin
            miscompares++;
            $display("[TB] FAIL same_data got=%h exp=00000042", rd_data[31:0]);
        end
        vectors++;
        if (rd_busy[0] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL same_busy got=%b exp=1", rd_busy[0]);
        end
        vectors++;
        if (pend_cnt !== 6'd1) begin
            miscompares++;
            $display("[TB] FAIL same_pend got=%0d exp=1", pend_cnt);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_data;
        logic        exp_busy;
        rsv_en   = 1'b1;
        rsv_addr = 5'd3;
        tick();
        idle();
        vectors++;
        if (pend_cnt !== 6'd2) begin
            miscompares++;
            $display("[TB] FAIL byp_pend_rsv got=%0d exp=2", pend_cnt);
        end
`ifdef REGFILE_BYPASS_EN
        exp_data = 32'h0000_0077;
        exp_busy = 1'b0;
`else
        exp_data = 32'h0;
        exp_busy = 1'b1;
`endif
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd3};
        wr_data = {32'h0, 32'h0000_0077};
        rd_addr = {5'd0, 5'd3};
        #1;
        vectors++;
        if (rd_data[31:0] !== exp_data) begin
            miscompares++;
            $display("[TB] FAIL byp_same_data got=%h exp=%h", rd_data[31:0], exp_data);
        end
        vectors++;
        if (rd_busy[0] !== exp_busy) begin
            miscompares++;
            $display("[TB] FAIL byp_same_busy got=%b exp=%b", rd_busy[0], exp_busy);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (rd_data[31:0] !== 32'h0000_0077) begin
            miscompares++;
            $display("[TB] FAIL byp_next_data got=%h exp=00000077", rd_data[31:0]);
        end
        vectors++;
        if (rd_busy[0] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL byp_next_busy got=%b exp=0", rd_busy[0]);
        end
        vectors++;
        if (pend_cnt !== 6'd1) begin
            miscompares++;
            $display("[TB] FAIL byp_next_pend got=%0d exp=1", pend_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_data;
        wr_en   = 2'b10;
        wr_addr = {5'd12, 5'd0};
        wr_data = {32'h0000_0011, 32'h0};
        tick();
`ifdef REGFILE_BYPASS_EN
        exp_data = 32'h0000_0022;
`else
        exp_data = 32'h0000_0011;
`endif
        wr_data = {32'h0000_0022, 32'h0};
        rd_addr = {5'd12, 5'd12};
        #1;
        vectors++;
        if (rd_data[31:0] !== exp_data) begin
            miscompares++;
            $display("[TB] FAIL b2b_mid got=%h exp=%h", rd_data[31:0], exp_data);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (rd_data[63:32] !== 32'h0000_0022) begin
            miscompares++;
            $display("[TB] FAIL b2b_final got=%h exp=00000022", rd_data[63:32]);
        end
    endtask

    task automatic test_reset_mid();
        wr_en    = 2'b11;
        wr_addr  = {5'd10, 5'd11};
        wr_data  = {32'h0000_0055, 32'h0000_0066};
        rsv_en   = 1'b1;
        rsv_addr = 5'd13;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        for (int a = 1; a < 32; a += 2) begin
            rd_addr = {5'(a + 1), 5'(a)};
            #1;
            vectors++;
            if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
                miscompares++;
                $display("[TB] FAIL midrst_read addr=%0d got=%h/%b exp=0/00", a, rd_data, rd_busy);
            end
        end
        vectors++;
        if (pend_cnt !== 6'd0) begin
            miscompares++;
            $display("[TB] FAIL midrst_pend got=%0d exp=0", pend_cnt);
        end
        vectors++;
        if (rsv_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midrst_rsv_err got=%b exp=0", rsv_err);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_write_priority();
        test_addr_zero();
        test_reserve();
        test_rsv_write_same();
        test_bypass();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
